pool1_seq: RTL and testbench
============================

POOL1_SEQ -- requirements
Module: pool1_seq

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 18, giving the number of feature-map channels per frame.
REQ-002 The block SHALL have parameter IN_DIM, default 24, giving the input map width and height; it is even and at least 4.
REQ-003 The block SHALL have derived localparams:
- OUT_DIM = IN_DIM/2.
- CW = $clog2(CHANNELS).
- RW = $clog2(OUT_DIM).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 busy  output  1  high from accepted start until done.
REQ-008 done  output  1  one-cycle pulse when the frame completes.
REQ-009 in_valid  input  1  an input row is present.
REQ-010 in_ready  output  1  the block accepts an input row this cycle.
REQ-011 in_row  input  [0:IN_DIM-1]  one binary feature-map row; bit 0 is column 0.
REQ-012 out_valid  output  1  a pooled row is present.
REQ-013 out_ready  input  1  downstream accepts the pooled row.
REQ-014 out_row  output  [0:OUT_DIM-1]  pooled binary row; bit 0 is output column 0.
REQ-015 out_ch  output  CW  channel index of out_row.
REQ-016 out_idx  output  RW  output row index (0..OUT_DIM-1).
REQ-017 out_last  output  1  out_row is the final row of the frame.

Function
REQ-018 Input rows SHALL arrive channel-major then row-major: CHANNELS*IN_DIM rows per frame.
REQ-019 Output rows SHALL leave in the same order: CHANNELS*OUT_DIM rows per frame.
REQ-020 A transfer SHALL occur on a channel only when valid and ready are both high on the same rising edge.
REQ-021 The FSM SHALL have states IDLE, EVEN, ODD and FLUSH.
REQ-022 IDLE: in_ready=0; start=1 clears the channel and row counters and goes to EVEN.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 EVEN: in_ready=1; an accepted row is stored in row_buf and the FSM goes to ODD.
REQ-025 ODD: in_ready SHALL equal (!out_valid || out_ready), i.e. the output register is free or being drained this cycle.
REQ-026 On an accepted ODD row, each output bit SHALL be set as follows, registered:
- out_row[j] = row_buf[2j] | row_buf[2j+1] | in_row[2j] | in_row[2j+1] (2x2 binary max-pool).
REQ-027 On that accept, out_valid SHALL be set together with out_ch, out_idx and out_last, registered.
REQ-028 Pooling latency SHALL be 1 cycle: out_valid is high on the cycle after the odd row is accepted.
REQ-029 out_valid, out_row, out_ch, out_idx and out_last SHALL be held stable until the handshake completes.
REQ-030 out_valid SHALL clear after handshake unless a new pooled row is loaded on the same edge.
REQ-031 After an ODD accept, the counters SHALL advance as follows:
- The row counter (0..OUT_DIM-1) increments.
- On wrap from OUT_DIM-1, the row counter returns to 0 and the channel counter increments.
REQ-032 After an ODD accept, the next state SHALL be EVEN, or FLUSH if the row was the last row of channel CHANNELS-1.
REQ-033 out_last SHALL be 1 only for channel CHANNELS-1, row OUT_DIM-1.
REQ-034 FLUSH: in_ready=0; when the out_last row completes its handshake, the block SHALL pulse done for 1 cycle, clear busy and return to IDLE.
REQ-035 busy SHALL be high in EVEN, ODD and FLUSH, and low in IDLE.
REQ-036 in_valid held high while in_ready=0 SHALL neither be consumed nor alter state.
REQ-037 A new EVEN row SHALL be accepted even while a previous out_row is still pending.
REQ-038 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-039 While rst_n=0, the outputs SHALL take these values:
- state = IDLE.
- busy, done, in_ready, out_valid, out_last = 0.
- out_row, out_ch, out_idx, and both counters = 0.
- row_buf = 0.
REQ-040 Reset asserted mid-frame SHALL discard all partial data.
REQ-041 No done pulse SHALL be produced for a frame aborted by reset.
REQ-042 After reset release, the block SHALL wait for a new start.

Verification
REQ-043 Full frame with out_ready=1 and in_valid always high:
- Exactly 216 out rows are produced.
- out_ch/out_idx go 0/0 .. 17/11.
- out_last is high only on 17/11.
- done pulses once, one cycle after that handshake.
REQ-044 Pooling values, channel 0:
- Input rows 0=24'h800000 and 1=24'h000001 -> out_row 12'h801.
- Input rows 2=0 and 3=0 -> 12'h000.
REQ-045 Backpressure: hold out_ready=0 after the first output:
- out_row stays stable.
- One further EVEN row is accepted.
- in_ready drops in ODD.
- Release out_ready -> stream resumes with no loss or duplication.
REQ-046 start pulsed while busy (mid-frame):
- Counters are unaffected.
- Only one done pulse is produced at frame end.
REQ-047 Reset mid-frame: assert rst_n=0 during channel 5:
- All outputs go to 0 immediately.
- No done pulse is produced.
- A new start yields a correct full frame beginning at 0/0.
REQ-048 Parameter override CHANNELS=2, IN_DIM=4:
- 4 output rows are produced.
- out_last is high on channel 1, row 1.
- done follows.

Source files
------------

// File: rtl/pool1_seq.sv
// pool1_seq: streaming 2x2 binary max-pool over CHANNELS feature maps of IN_DIM x IN_DIM.
// Even rows are buffered; each odd row combines with the buffer into one registered pooled row.
module pool1_seq #(
    parameter int CHANNELS = 18,
    parameter int IN_DIM   = 24,
    localparam int OUT_DIM = IN_DIM / 2,
    localparam int CW      = $clog2(CHANNELS),
    localparam int RW      = $clog2(OUT_DIM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:IN_DIM-1]  in_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:OUT_DIM-1] out_row,
    output logic [CW-1:0]      out_ch,
    output logic [RW-1:0]      out_idx,
    output logic               out_last
);

    typedef enum logic [1:0] {StIdle, StEven, StOdd, StFlush} state_t;

    state_t             r_state, w_state_nxt;
    logic [0:IN_DIM-1]  r_row_buf;
    logic [CW-1:0]      r_ch_cnt, w_ch_cnt_nxt;
    logic [RW-1:0]      r_row_cnt, w_row_cnt_nxt;
    logic               r_done, w_done_nxt;
    logic               r_out_valid, r_out_last;
    logic [0:OUT_DIM-1] r_out_row, w_pool;
    logic [CW-1:0]      r_out_ch;
    logic [RW-1:0]      r_out_idx;
    logic               w_in_ready, w_in_acc, w_out_acc, w_last_row, w_last_ch;

    assign w_last_row = (r_row_cnt == RW'(OUT_DIM - 1));
    assign w_last_ch  = (r_ch_cnt == CW'(CHANNELS - 1));
    assign w_in_acc   = in_valid && w_in_ready;
    assign w_out_acc  = r_out_valid && out_ready;

    // ODD may only accept when the output register is free or draining this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            StEven:  w_in_ready = 1'b1;
            StOdd:   w_in_ready = !r_out_valid || out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    always_comb begin
        for (int j = 0; j < OUT_DIM; j++) begin
            w_pool[j] = r_row_buf[2*j] | r_row_buf[2*j+1] | in_row[2*j] | in_row[2*j+1];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ch_cnt_nxt  = r_ch_cnt;
        w_row_cnt_nxt = r_row_cnt;
        w_done_nxt    = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt   = StEven;
                    w_ch_cnt_nxt  = '0;
                    w_row_cnt_nxt = '0;
                end
            end
            StEven: begin
                if (w_in_acc) w_state_nxt = StOdd;
            end
            StOdd: begin
                if (w_in_acc) begin
                    if (w_last_row) begin
                        w_row_cnt_nxt = '0;
                        w_ch_cnt_nxt  = r_ch_cnt + 1'b1;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + 1'b1;
                    end
                    w_state_nxt = (w_last_row && w_last_ch) ? StFlush : StEven;
                end
            end
            StFlush: begin
                if (w_out_acc && r_out_last) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_ch_cnt  <= '0;
            r_row_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch_cnt  <= w_ch_cnt_nxt;
            r_row_cnt <= w_row_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_buf   <= '0;
            r_out_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_ch    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == StEven && w_in_acc) r_row_buf <= in_row;
            if (r_state == StOdd && w_in_acc) begin
                r_out_valid <= 1'b1;
                r_out_row   <= w_pool;
                r_out_ch    <= r_ch_cnt;
                r_out_idx   <= r_row_cnt;
                r_out_last  <= w_last_row && w_last_ch;
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != StIdle);
    assign done      = r_done;
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_out_row;
    assign out_ch    = r_out_ch;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_pool1_seq.sv
// Scoreboard bench for pool1_seq: full frames, backpressure, mid-frame start/reset,
// plus a small CHANNELS=2, IN_DIM=4 instance.
module tb_pool1_seq;
    localparam int CH = 18;
    localparam int ID = 24;
    localparam int OD = 12;
    localparam int CW = 5;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [0:ID-1] in_row = '0;
    logic busy, done, in_ready, out_valid, out_last;
    logic [0:OD-1] out_row;
    logic [CW-1:0] out_ch;
    logic [RW-1:0] out_idx;

    logic b_start = 1'b0;
    logic b_in_valid = 1'b0;
    logic b_out_ready = 1'b1;
    logic [0:3] b_in_row = '0;
    logic b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
    logic [0:1] b_out_row;
    logic [0:0] b_out_ch, b_out_idx;

    always #5 clk = ~clk;

    pool1_seq #(.CHANNELS(CH), .IN_DIM(ID)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last)
    );

    pool1_seq #(.CHANNELS(2), .IN_DIM(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
        .out_ch(b_out_ch), .out_idx(b_out_idx), .out_last(b_out_last)
    );

    typedef struct packed {
        logic [0:OD-1] row;
        logic [CW-1:0] ch;
        logic [RW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_out = 0;
    int n_done = 0;
    int hs_cyc = -10;
    logic mon_en = 1'b0;
    logic [0:ID-1] prev_row = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [0:ID-1] pat(input int c, input int r);
        logic [0:ID-1] v;
        v = '0;
        if (c == 0 && r == 0) v = 24'h800000;
        else if (c == 0 && r == 1) v = 24'h000001;
        else if (c == 0 && r < 4) v = '0;
        else if ((c + r) % 3 != 0) v[(c * 7 + r * 5) % ID] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:OD-1] pool(input logic [0:ID-1] a, input logic [0:ID-1] b);
        logic [0:OD-1] v;
        for (int j = 0; j < OD; j++) v[j] = a[2*j] | a[2*j+1] | b[2*j] | b[2*j+1];
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: head of queue must match whenever out_valid is high; pop on handshake.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    check("out_row", out_row, q[0].row);
                    check("out_ch", out_ch, q[0].ch);
                    check("out_idx", out_idx, q[0].idx);
                    check("out_last", out_last, q[0].last);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                        hs_cyc = cyc;
                    end
                end
            end
            if (done) begin
                n_done++;
                check("done_timing", cyc, hs_cyc + 1);
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_row(input int c, input int r);
        int t;
        exp_t e;
        t = 0;
        in_valid = 1'b1;
        in_row = pat(c, r);
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        if (r % 2 == 1) begin
            if (c == 0 && r == 1) e.row = 12'h801;
            else if (c == 0 && r == 3) e.row = 12'h000;
            else e.row = pool(prev_row, pat(c, r));
            e.ch = CW'(c);
            e.idx = RW'(r / 2);
            e.last = (c == CH - 1 && r == ID - 1);
            q.push_back(e);
        end else begin
            prev_row = pat(c, r);
        end
    endtask

    task automatic run_frame(input bit bp, input bit mid_start);
        int t;
        n_out = 0;
        n_done = 0;
        out_ready = !bp;
        do_start();
        for (int c = 0; c < CH; c++) begin
            for (int r = 0; r < ID; r++) begin
                if (mid_start && c == 3 && r == 0) start = 1'b1;
                send_row(c, r);
                start = 1'b0;
                if (bp && c == 0 && r == 2) begin
                    in_row = pat(0, 3);
                    repeat (4) @(negedge clk);
                    check("bp_in_ready_odd", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    check("bp_pending", q.size(), 1);
                    @(posedge clk); #1;
                    out_ready = 1'b1;
                end
            end
        end
        t = 0;
        while (n_done == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_count", n_done, 1);
        check("out_count", n_out, CH * OD);
        check("busy_after", busy, 0);
        check("queue_empty", q.size(), 0);
        in_valid = 1'b0;
    endtask

    task automatic send_small(input logic [0:3] row);
        int t;
        t = 0;
        b_in_valid = 1'b1;
        b_in_row = row;
        do begin
            @(negedge clk);
            t++;
        end while (!b_in_ready && t < 50);
        if (!b_in_ready) check("small_in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    logic [0:3] s_rows [8] = '{4'b1000, 4'b0000, 4'b0001, 4'b0010,
                               4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [0:1] s_exp [4] = '{2'b10, 2'b01, 2'b00, 2'b10};

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_idx", out_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        run_frame(1'b0, 1'b1);

        // Abort a frame partway through channel 5.
        n_done = 0;
        do_start();
        for (int c = 0; c < 6; c++) begin
            for (int r = 0; r < ID; r++) begin
                if (!(c == 5 && r > 3)) send_row(c, r);
            end
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_row", out_row, 0);
        check("abort_out_ch", out_ch, 0);
        check("abort_out_idx", out_idx, 0);
        check("abort_out_last", out_last, 0);
        q.delete();
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_done", n_done, 0);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_in_ready", in_ready, 0);
        in_valid = 1'b0;

        run_frame(1'b1, 1'b0);

        // Small instance: CHANNELS=2, IN_DIM=4.
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_small(s_rows[k]);
            if (k % 2 == 1) begin
                check("small_out_valid", b_out_valid, 1);
                check("small_out_row", b_out_row, s_exp[k/2]);
                check("small_out_ch", b_out_ch, (k / 4));
                check("small_out_idx", b_out_idx, ((k / 2) % 2));
                check("small_out_last", b_out_last, (k == 7));
            end
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        check("small_done", b_done, 1);
        check("small_busy", b_busy, 0);
        @(posedge clk); #1;
        check("small_done_pulse", b_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
